// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: Moore FSM issuing per-cycle datapath strobes,
// with memory wait-state handling, a stall watchdog and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             busy,
    output logic             mem_timeout,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Counter only needs to reach WAIT_LIMIT; with the watchdog disabled it may wrap harmlessly.
    localparam int WCNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM_V = WCNT_W'(WAIT_LIMIT);

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
    logic               ill_q, ill_d;
    logic               stall;
    logic               retire;

    // Next-state, stall watchdog and retirement bookkeeping.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ill_d   = ill_q;
        stall   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:      if (start) state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE; else stall = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_HALT;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB; else stall = 1'b1;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase

        // A completing access (mem_ready=1) never reaches here, so it wins over the watchdog.
        if (stall && (WAIT_LIMIT != 0) && (wait_q == WAIT_LIM_V)) begin
            state_d = S_HALT;
            tmo_d   = 1'b1;
        end

        if (state_d != state_q) wait_d = '0;
        else if (stall)         wait_d = wait_q + 1'b1;
        else                    wait_d = wait_q;

        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ill_q   <= ill_d;
        end
    end

    // Moore control decode; only FETCH (mem_ready) and BRANCH (alu_zero) qualify a strobe.
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_WB:   reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = alu_zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign mem_timeout = tmo_q;
    assign illegal_op  = ill_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: vector table, directed corner cases,
// and randomized stimulus against an instruction-level reference model.
module tb_multicycle_sequencer;

    logic        clock, reset, start, alu_zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic        alu_src_a, busy, mem_timeout, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_sequencer #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .busy(busy), .mem_timeout(mem_timeout), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [14:0] ctrl();
        return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Instruction flow as a list of named steps; the control word of each step is written
    // from the strobe table of the datapath, with qualified terms passed in.
    int          m_st, m_wait, m_cnt;
    logic        m_tmo, m_ill;

    function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic az);
        logic pw, iod, mrd, mwr, irw, rd, m2r, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pw, iod, mrd, mwr, irw, rd, m2r, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            1:      begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            2:      asb = 2'b11;
            3, 11:  begin asa = 1; asb = 2'b10; end
            4:      begin mrd = 1; iod = 1; end
            5:      begin rw = 1; m2r = 1; end
            6:      begin mwr = 1; iod = 1; end
            7:      begin asa = 1; aop = 2'b10; end
            8:      begin rw = 1; rd = 1; end
            9:      begin asa = 1; aop = 2'b01; pcs = 2'b01; pw = az; end
            10:     begin pcs = 2'b10; pw = 1; end
            12:     rw = 1;
            default: ;
        endcase
        return {pw, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, pcs};
    endfunction

    function automatic bit is_mem_wait(input int st);
        return (st == 1) || (st == 4) || (st == 6);
    endfunction

    // One clock of the model, given the inputs present before the edge.
    task automatic model_step(input logic st_i, input logic [5:0] op, input logic mr);
        int nxt;
        nxt = m_st;
        if (is_mem_wait(m_st) && !mr) begin
            if (m_wait == 15) begin nxt = 13; m_tmo = 1; end
            else m_wait++;
        end else begin
            case (m_st)
                0:  nxt = st_i ? 1 : 0;
                1:  nxt = 2;
                2: begin
                    if (op == 6'h00)                    nxt = 7;
                    else if (op == 6'h23 || op == 6'h2B) nxt = 3;
                    else if (op == 6'h04)               nxt = 9;
                    else if (op == 6'h02)               nxt = 10;
                    else if (op == 6'h08)               nxt = 11;
                    else if (op == 6'h3F) begin nxt = 13; m_cnt++; end
                    else begin nxt = 13; m_ill = 1; end
                end
                3:  nxt = (op == 6'h23) ? 4 : 6;
                4:  nxt = 5;
                7:  nxt = 8;
                11: nxt = 12;
                5, 6, 8, 9, 10, 12: begin nxt = 1; m_cnt++; end
                default: nxt = 13;
            endcase
        end
        if (nxt != m_st) m_wait = 0;
        m_st = nxt;
    endtask

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_cnt = 0; m_tmo = 0; m_ill = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic [5:0]  op;
        logic        az;
        logic        mr;
        logic [3:0]  exp_state;
        logic [14:0] exp_ctrl;
        int          exp_cnt;
    } vec_t;

    vec_t tv[11];

    initial begin
        // R-type, then beq taken, then beq not taken; mem_ready always 1.
        tv[0]  = '{1'b1, 6'h00, 1'b0, 1'b1, 4'd1, 15'b10101_0000_01_00_00, 0};
        tv[1]  = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd2, 15'b00000_0000_11_00_00, 0};
        tv[2]  = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd7, 15'b00000_0001_00_10_00, 0};
        tv[3]  = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd8, 15'b00000_1010_00_00_00, 0};
        tv[4]  = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd1, 15'b10101_0000_01_00_00, 1};
        tv[5]  = '{1'b0, 6'h04, 1'b1, 1'b1, 4'd2, 15'b00000_0000_11_00_00, 1};
        tv[6]  = '{1'b0, 6'h04, 1'b1, 1'b1, 4'd9, 15'b10000_0001_00_01_01, 1};
        tv[7]  = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd1, 15'b10101_0000_01_00_00, 2};
        tv[8]  = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd2, 15'b00000_0000_11_00_00, 2};
        tv[9]  = '{1'b0, 6'h04, 1'b0, 1'b1, 4'd9, 15'b00000_0001_00_01_01, 2};
        tv[10] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd1, 15'b10101_0000_01_00_00, 3};
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 0; opcode = 6'h00; alu_zero = 0; mem_ready = 1;
        #12;
        check("reset_state", state, 0);
        check("reset_ctrl", ctrl(), 0);
        check("reset_flags", {busy, mem_timeout, illegal_op}, 0);
        check("reset_cnt", instr_count, 0);
        @(negedge clock);
        reset = 1'b0;
        #3;

        // Table vectors: inputs held across the edge, outputs checked after it.
        for (int i = 0; i < 11; i++) begin
            start = tv[i].st; opcode = tv[i].op; alu_zero = tv[i].az; mem_ready = tv[i].mr;
            tick();
            check($sformatf("tv%0d_state", i), state, tv[i].exp_state);
            check($sformatf("tv%0d_ctrl", i), ctrl(), tv[i].exp_ctrl);
            check($sformatf("tv%0d_cnt", i), instr_count, tv[i].exp_cnt);
        end

        // lw with three wait states in MEM_READ.
        do_reset();
        start = 1; mem_ready = 1; opcode = 6'h23;
        tick(); start = 0;
        tick(); tick(); tick();
        check("lw_memread", state, 4);
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lw_stall%0d", i), {state, ctrl()}, {4'd4, 15'b01100_0000_00_00_00});
            tick();
        end
        check("lw_stall3", {state, ctrl()}, {4'd4, 15'b01100_0000_00_00_00});
        mem_ready = 1;
        tick();
        check("lw_memwb", {state, mem_to_reg, reg_write, reg_dst}, {4'd5, 3'b110});
        tick();
        check("lw_retire", {state, instr_count}, {4'd1, 32'd1});

        // Watchdog: 16 stalled cycles in FETCH end in HALT.
        do_reset();
        start = 1; mem_ready = 0;
        tick(); start = 0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("wd_fetch%0d", i), {state, pc_write, ir_write, mem_read}, {4'd1, 3'b001});
            tick();
        end
        check("wd_fetch15", state, 1);
        tick();
        check("wd_halt", {state, mem_timeout, busy, instr_count}, {4'd13, 1'b1, 1'b0, 32'd0});

        // Ready on the limit cycle completes the fetch instead of timing out.
        do_reset();
        start = 1; mem_ready = 0;
        tick(); start = 0;
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1;
        tick();
        check("wd_ready_wins", {state, mem_timeout}, {4'd2, 1'b0});

        // Illegal opcode, HALT ignores start, reset recovers.
        do_reset();
        start = 1; mem_ready = 1; opcode = 6'h15;
        tick(); start = 0;
        tick(); tick();
        check("ill_halt", {state, illegal_op, instr_count}, {4'd13, 1'b1, 32'd0});
        start = 1;
        tick(); tick();
        check("halt_sticky", {state, busy}, {4'd13, 1'b0});
        start = 0;
        do_reset();
        check("ill_reset", {state, illegal_op, mem_timeout}, 0);

        // sw, async reset in the next FETCH, then sw + halt opcode.
        start = 1; mem_ready = 1; opcode = 6'h2B;
        tick(); start = 0;
        tick(); tick(); mem_ready = 0; tick();
        check("sw_write", {state, mem_write, i_or_d}, {4'd6, 2'b11});
        mem_ready = 1;
        tick();
        check("sw_retire", {state, instr_count}, {4'd1, 32'd1});
        reset = 1;
        #1;
        check("async_rst", {state, ctrl(), busy, instr_count}, 0);
        reset = 0;
        start = 1;
        tick(); start = 0;
        tick(); tick(); tick(); tick();
        check("sw2_retire", {state, instr_count}, {4'd1, 32'd1});
        opcode = 6'h3F;
        tick(); tick();
        check("halt_op", {state, illegal_op, instr_count}, {4'd13, 1'b0, 32'd2});

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [5:0] ops[8];
            ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h15};
            r = $urandom_range(0, 99);
            opcode    = (r < 94) ? ops[$urandom_range(0, 5)] : ops[$urandom_range(6, 7)];
            start     = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            model_step(start, opcode, mem_ready);
            tick();
            check($sformatf("rnd%0d", i),
                  {state, ctrl(), busy, mem_timeout, illegal_op, instr_count},
                  {4'(m_st), exp_ctrl(m_st, mem_ready, alu_zero),
                   1'(m_st != 0 && m_st != 13), m_tmo, m_ill, 32'(m_cnt)});
            if ((m_st == 13 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Moore control FSM that runs a multicycle version of the CPU datapath: one shared Memory for instruction and data, an IR, and ALUOut/MDR holding registers.
- It replaces the combinational per-instruction decode with a per-cycle sequence of control strobes for PC, memory, IR, register file, ALU muxes and ALU.
- It also applies memory wait-state handshaking, a stall watchdog, and a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive stalled cycles allowed in one memory state; 0 disables the watchdog.
- CNT_W, 32: width of instr_count.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begins execution from IDLE.
- opcode  in  6  IR[31:26], sampled in DECODE.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode from funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding.
- busy  out  1  high in every state except IDLE and HALT.
- mem_timeout  out  1  sticky flag; watchdog fired.
- illegal_op  out  1  sticky flag; unknown opcode decoded.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- Reset: state = IDLE; wait counter = 0; instr_count = 0; flags = 0. All strobes are 0 and all selects are 0 while in IDLE.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6
  - R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, HALT=13
  - Encodings 14 and 15 go to HALT on the next edge.
- Outputs are decoded from state only, except the qualified terms noted below. Any signal not listed for a state is 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target into ALUOut).
  - MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - ADDI_WB: reg_write=1, reg_dst=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=alu_zero.
  - JUMP: pc_source=10, pc_write=1.
- Transitions:
  - IDLE: go to FETCH if start=1, otherwise stay.
  - FETCH: go to DECODE once mem_ready=1.
  - DECODE, by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - 111111 -> HALT (counts as retired)
    - any other -> HALT with illegal_op=1 (not counted)
  - MEM_ADDR: go to MEM_READ if opcode=100011, otherwise MEM_WRITE.
  - MEM_READ: go to MEM_WB once mem_ready=1.
  - MEM_WRITE: go to FETCH once mem_ready=1.
  - R_EXEC -> R_WB; ADDI_EXEC -> ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: go to FETCH.
  - HALT: terminal; only reset exits it; start is ignored.
- Stall handling:
  - In FETCH, MEM_READ or MEM_WRITE with mem_ready=0: hold state and hold all strobes.
  - The wait counter increments each stalled cycle and clears on any state change.
  - If WAIT_LIMIT != 0 and the counter equals WAIT_LIMIT while still stalled, go to HALT next edge with mem_timeout=1.
  - mem_ready=1 on that same cycle wins: the access completes normally.
- Retirement: instr_count increments by 1 on each transition into FETCH from a final state, and on DECODE -> HALT for opcode 111111. It wraps from all-ones to 0.
- start is ignored outside IDLE.
- Reset mid-instruction or mid-stall: immediate return to IDLE, all outputs 0, counters cleared.

Test Plan:
- Reset, start=1 for 1 cycle, mem_ready=1, R-type opcode: state 0->1->2->7->8->1, reg_write=1 with reg_dst=1 in R_WB, instr_count=1.
- lw with mem_ready held 0 for 3 cycles in MEM_READ: MEM_READ lasts 4 cycles with mem_read=1 and i_or_d=1 stable, then MEM_WB with mem_to_reg=1.
- beq: with alu_zero=1, pc_write=1 and pc_source=01 in BRANCH. Repeat with alu_zero=0: pc_write=0. Both give instr_count +1.
- WAIT_LIMIT=15, mem_ready=0 in FETCH: HALT after 16 cycles in FETCH, mem_timeout=1, busy=0, instr_count unchanged.
- Opcode 010101: DECODE -> HALT, illegal_op=1. Then start=1: stays in HALT. Then reset: IDLE, flags=0.
- sw then opcode 111111: MEM_WRITE with mem_write=1, then HALT, instr_count=2. Assert reset during the following FETCH: all outputs 0 asynchronously.
